ras_stack: RTL and testbench
============================

// Module: ras_stack
// PURPOSE
// Return-address stack for the frontend. It feeds return-target predictions
// (cf = Return) that the branch unit later checks against the computed JALR target.
// - Pushes the link PC on predicted calls; pops on predicted returns.
// - Drops all speculative state when the branch unit reports a resolved mispredict,
//   or on a pipeline flush.
// - Circular storage; the oldest entry is overwritten on overflow.
// PARAMETERS
// DEPTH  2   number of entries (power of two, >=2)
// VLEN   39  virtual address width (riscv::VLEN)
// PORTS
// clk_i              in   1              clock, rising edge
// rst_i              in   1              synchronous reset, active-high
// flush_i            in   1              clear stack (pipeline flush / fence.i)
// push_i             in   1              predicted call: push data_i
// pop_i              in   1              predicted return: pop top entry
// data_i             in   VLEN           link address to push (pc + 2/4)
// resolve_valid_i    in   1              resolved_branch.valid from branch unit
// resolve_misp_i     in   1              resolved_branch.is_mispredict
// top_valid_o        out  1              top entry holds a valid prediction
// top_addr_o         out  VLEN           predicted return address (top of stack)
// count_o            out  $clog2(DEPTH)+1  number of valid entries
// overflow_o         out  1              1-cycle pulse: valid entry overwritten
// BEHAVIOUR
// - State: mem[DEPTH] addresses, vld[DEPTH] bits, tos pointer, count.
//   Outputs are read combinationally from registers: zero-latency top readout.
// - Reset (rst_i=1 at posedge): tos=0, count=0, all vld=0, mem=0.
//   Consequently top_valid_o=0, top_addr_o=0, count_o=0, overflow_o=0.
//   Reset wins over all other inputs.
// - Clear: flush_i=1, or (resolve_valid_i & resolve_misp_i), has the same effect as reset.
//   It is applied at the next edge and wins over push/pop in the same cycle.
// - Push only: tos=tos+1 mod DEPTH, mem[tos+1]=data_i, vld[tos+1]=1, count=min(count+1,DEPTH).
//   If count==DEPTH before the push: the oldest entry is overwritten and overflow_o=1
//   for that cycle (overflow_o is combinational).
// - Pop only:
//   - count>0: vld[tos]=0, tos=tos-1 mod DEPTH, count-1.
//   - count==0: no state change; top_valid_o stays 0.
// - Push+pop same cycle (return then call): top replaced in place.
//   - mem[tos]=data_i, vld[tos]=1; tos unchanged.
//   - count=max(count,1); overflow_o=0.
// - top_valid_o = vld[tos]; top_addr_o = mem[tos] (0 when not valid).
// - Pointer arithmetic wraps modulo DEPTH.
// - Widths: count_o saturates at DEPTH and never exceeds it.
// - Stored addresses are raw link PCs. No encoding is applied inside this block.
// - resolve_valid_i without resolve_misp_i has no effect.
// TESTING
// 1. Reset, then push 0x100, push 0x200 ->
//    count_o=2, top_addr_o=0x200, top_valid_o=1.
// 2. From (1), pop, then pop, then pop ->
//    top 0x100 (count 1); then top_valid_o=0, count 0; third pop: no change, no X.
// 3. DEPTH=2: push 0xA, 0xB, 0xC ->
//    overflow_o=1 on the third push; count_o=2; pops return 0xC then 0xB; then empty.
// 4. Stack {0x100,0x200}, push+pop with data_i=0x300 ->
//    count_o=2, top 0x300; pop -> top 0x100.
// 5. Stack non-empty; resolve_valid_i=1, resolve_misp_i=1 with push_i=1 ->
//    next cycle count_o=0, top_valid_o=0 (clear beats push).
// 6. Mid-sequence rst_i=1 for 1 cycle with push_i=1 ->
//    all outputs 0 after the edge; subsequent push 0x40 gives count 1, top 0x40.

Source files
------------

// File: rtl/ras_stack.sv
// Return-address stack for the frontend fetch path.
// A circular buffer of link PCs that predicts return targets. Calls push and
// returns pop. A flush or a resolved mispredict drops all speculative
// contents. When the stack is full, the oldest entry is overwritten.
module ras_stack #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned VLEN  = 39
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [VLEN-1:0]            data_i,
  input  logic                       resolve_valid_i,
  input  logic                       resolve_misp_i,
  output logic                       top_valid_o,
  output logic [VLEN-1:0]            top_addr_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Storage and bookkeeping state
  logic [VLEN-1:0] mem_q [DEPTH];
  logic [VLEN-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    tos_q, tos_d;
  logic [CW-1:0]    count_q, count_d;

  logic          clear_s;
  logic          full_s;
  logic          empty_s;
  logic          overflow_s;
  logic [PW-1:0] tos_inc_s;
  logic [PW-1:0] tos_dec_s;

  // Pointer step helpers. DEPTH is a power of two, so the natural
  // truncation of the PW-bit sum gives modulo-DEPTH wrap.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return p + PW'(1);
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return p - PW'(1);
  endfunction

  assign clear_s   = flush_i | (resolve_valid_i & resolve_misp_i);
  assign full_s    = (count_q == FULL_CNT);
  assign empty_s   = (count_q == {CW{1'b0}});
  assign tos_inc_s = ptr_inc(tos_q);
  assign tos_dec_s = ptr_dec(tos_q);

  // Next-state computation: clear beats push/pop; push+pop replaces the top in place
  always_comb begin
    tos_d      = tos_q;
    count_d    = count_q;
    vld_d      = vld_q;
    mem_d      = mem_q;
    overflow_s = 1'b0;

    if (clear_s) begin
      tos_d   = {PW{1'b0}};
      count_d = {CW{1'b0}};
      vld_d   = {DEPTH{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_d[i] = {VLEN{1'b0}};
      end
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          // Call: advance and write. When full, the slot ahead of tos is the oldest entry.
          tos_d            = tos_inc_s;
          mem_d[tos_inc_s] = data_i;
          vld_d[tos_inc_s] = 1'b1;
          if (full_s) begin
            overflow_s = 1'b1;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
        2'b01: begin
          // Return: an empty stack ignores the pop.
          if (!empty_s) begin
            vld_d[tos_q] = 1'b0;
            tos_d        = tos_dec_s;
            count_d      = count_q - CW'(1);
          end else begin
            count_d = count_q;
          end
        end
        2'b11: begin
          // Return followed by a call: the net effect is to overwrite the current top.
          mem_d[tos_q] = data_i;
          vld_d[tos_q] = 1'b1;
          if (empty_s) begin
            count_d = CW'(1);
          end else begin
            count_d = count_q;
          end
        end
        default: begin
          tos_d = tos_q;
        end
      endcase
    end
  end

  // State registers with synchronous reset that overrides every other input
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tos_q   <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
      vld_q   <= {DEPTH{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= {VLEN{1'b0}};
      end
    end else begin
      tos_q   <= tos_d;
      count_q <= count_d;
      vld_q   <= vld_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Zero-latency readout of the top entry. The address is masked when the entry is not valid.
  always_comb begin
    top_valid_o = vld_q[tos_q];
    if (vld_q[tos_q]) begin
      top_addr_o = mem_q[tos_q];
    end else begin
      top_addr_o = {VLEN{1'b0}};
    end
  end

  assign count_o    = count_q;
  // No entry is overwritten when reset is asserted in the same cycle.
  assign overflow_o = overflow_s & ~rst_i;

endmodule

// File: tb/tb_ras_stack.sv
// Self-checking bench for ras_stack (DEPTH=2, VLEN=39).
// The first phase applies a table of directed vectors with hand-derived
// expectations. The second phase applies random traffic checked against a
// queue-based reference stack. Expected results go into a scoreboard queue
// when stimulus is driven. They are popped and compared when the DUT
// responds: overflow is checked before the edge, and the state is checked
// after the edge.
module tb_ras_stack;

  localparam int DEPTH = 2;
  localparam int VLEN  = 39;

  logic            clk = 1'b0;
  logic            rst, flush, push, pop, rv, rm;
  logic [VLEN-1:0] data;
  logic            top_valid;
  logic [VLEN-1:0] top_addr;
  logic [1:0]      count;
  logic            overflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic            rst, flush, push, pop, rv, rm;
    logic [VLEN-1:0] data;
    logic            ev;
    logic [VLEN-1:0] ea;
    logic [1:0]      ec;
    logic            eo;
  } vec_t;

  typedef struct {
    logic            v;
    logic [VLEN-1:0] a;
    logic [1:0]      c;
    logic            o;
    string           tag;
  } exp_t;

  vec_t            tbl [26];
  exp_t            sb [$];
  logic [VLEN-1:0] mq [$];

  always #5 clk = ~clk;

  ras_stack #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .push_i(push), .pop_i(pop),
    .data_i(data), .resolve_valid_i(rv), .resolve_misp_i(rm),
    .top_valid_o(top_valid), .top_addr_o(top_addr), .count_o(count),
    .overflow_o(overflow)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  function automatic vec_t mk(input logic r, f, pu, po, v1, m1, input logic [VLEN-1:0] d,
                              input logic ev, input logic [VLEN-1:0] ea,
                              input logic [1:0] ec, input logic eo);
    vec_t t;
    t.rst = r; t.flush = f; t.push = pu; t.pop = po; t.rv = v1; t.rm = m1; t.data = d;
    t.ev = ev; t.ea = ea; t.ec = ec; t.eo = eo;
    return t;
  endfunction

  // Reference stack: newest at the back; the oldest is dropped past DEPTH.
  task automatic model_step(input logic r, f, pu, po, v1, m1, input logic [VLEN-1:0] d,
                            output exp_t e);
    e.o = 1'b0;
    if (r || f || (v1 && m1)) begin
      mq.delete();
    end else if (pu && po) begin
      if (mq.size() == 0) mq.push_back(d);
      else mq[mq.size()-1] = d;
    end else if (pu) begin
      e.o = (mq.size() == DEPTH);
      mq.push_back(d);
      if (mq.size() > DEPTH) void'(mq.pop_front());
    end else if (po) begin
      if (mq.size() > 0) void'(mq.pop_back());
    end
    e.v = (mq.size() > 0);
    e.a = (mq.size() > 0) ? mq[mq.size()-1] : '0;
    e.c = 2'(mq.size());
  endtask

  task automatic apply(input logic r, f, pu, po, v1, m1, input logic [VLEN-1:0] d,
                       input exp_t e);
    exp_t got;
    @(negedge clk);
    rst = r; flush = f; push = pu; pop = po; rv = v1; rm = m1; data = d;
    sb.push_back(e);
    #1;
    check({sb[0].tag, ".overflow"}, {63'd0, overflow}, {63'd0, sb[0].o});
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check({got.tag, ".top_valid"}, {63'd0, top_valid}, {63'd0, got.v});
    check({got.tag, ".top_addr"},  {25'd0, top_addr},  {25'd0, got.a});
    check({got.tag, ".count"},     {62'd0, count},     {62'd0, got.c});
  endtask

  initial begin
    exp_t e;
    logic r, f, pu, po, v1, m1;
    logic [VLEN-1:0] d;

    rst = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; rv = 1'b0; rm = 1'b0; data = '0;

    //            rst  fl   push pop  rv   rm   data        ev   ea           ec    eo
    tbl[0]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,39'h0,   1'b0,39'h0,   2'd0,1'b0);
    tbl[1]  = mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,39'h100, 1'b1,39'h100, 2'd1,1'b0);
    tbl[2]  = mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,39'h200, 1'b1,39'h200, 2'd2,1'b0);
    tbl[3]  = mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,39'h0,   1'b1,39'h100, 2'd1,1'b0);
    tbl[4]  = mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,39'h0,   1'b0,39'h0,   2'd0,1'b0);
    tbl[5]  = mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,39'h0,   1'b0,39'h0,   2'd0,1'b0);
    tbl[6]  = mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,39'hA,   1'b1,39'hA,   2'd1,1'b0);
    tbl[7]  = mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,39'hB,   1'b1,39'hB,   2'd2,1'b0);
    tbl[8]  = mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,39'hC,   1'b1,39'hC,   2'd2,1'b1);
    tbl[9]  = mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,39'h0,   1'b1,39'hB,   2'd1,1'b0);
    tbl[10] = mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,39'h0,   1'b0,39'h0,   2'd0,1'b0);
    tbl[11] = mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,39'h100, 1'b1,39'h100, 2'd1,1'b0);
    tbl[12] = mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,39'h200, 1'b1,39'h200, 2'd2,1'b0);
    tbl[13] = mk(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,39'h300, 1'b1,39'h300, 2'd2,1'b0);
    tbl[14] = mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,39'h0,   1'b1,39'h100, 2'd1,1'b0);
    tbl[15] = mk(1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,39'h500, 1'b0,39'h0,   2'd0,1'b0);
    tbl[16] = mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,39'h10,  1'b1,39'h10,  2'd1,1'b0);
    tbl[17] = mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,39'h20,  1'b0,39'h0,   2'd0,1'b0);
    tbl[18] = mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,39'h40,  1'b1,39'h40,  2'd1,1'b0);
    tbl[19] = mk(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,39'h50,  1'b1,39'h50,  2'd2,1'b0);
    tbl[20] = mk(1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,39'h0,   1'b0,39'h0,   2'd0,1'b0);
    tbl[21] = mk(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,39'h77,  1'b1,39'h77,  2'd1,1'b0);
    tbl[22] = mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,39'h88,  1'b1,39'h88,  2'd2,1'b0);
    tbl[23] = mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,39'h99,  1'b1,39'h99,  2'd2,1'b1);
    tbl[24] = mk(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,39'h66,  1'b1,39'h66,  2'd2,1'b0);
    tbl[25] = mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,39'h0,   1'b1,39'h88,  2'd1,1'b0);

    // Directed phase: the table holds the expected values.
    for (int i = 0; i < 26; i++) begin
      e.v = tbl[i].ev; e.a = tbl[i].ea; e.c = tbl[i].ec; e.o = tbl[i].eo;
      e.tag = $sformatf("vec%0d", i);
      apply(tbl[i].rst, tbl[i].flush, tbl[i].push, tbl[i].pop, tbl[i].rv, tbl[i].rm,
            tbl[i].data, e);
    end

    // Random phase: the reference stack supplies the expected values. A reset comes first so the model starts aligned.
    for (int i = 0; i < 400; i++) begin
      r  = (i == 0) || ($urandom_range(0, 99) < 2);
      f  = ($urandom_range(0, 99) < 4);
      v1 = ($urandom_range(0, 99) < 15);
      m1 = ($urandom_range(0, 99) < 30);
      pu = ($urandom_range(0, 99) < 50);
      po = ($urandom_range(0, 99) < 40);
      d  = {$urandom(), $urandom()} & {VLEN{1'b1}};
      model_step(r, f, pu, po, v1, m1, d, e);
      e.tag = $sformatf("rnd%0d", i);
      apply(r, f, pu, po, v1, m1, d, e);
    end

    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    @(negedge clk);
    push = 1'b0; pop = 1'b0; flush = 1'b0; rst = 1'b0; rv = 1'b0; rm = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
